mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter onto one memory port with lock, timeout and size abort.
// Define MEM_ARB_ALIGN_CHECK_EN to abort misaligned data accesses instead of forcing alignment.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic        if_abort,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_lock,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic        d_abort,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, BUS, RESP, ABORT} state_t;
    state_t      state;
    logic        last_d, lock, gnt_d, g_lock;
    logic [1:0]  sz, off, size_g;
    logic [7:0]  cnt;
    logic        pick_d, go, bad;
    logic [31:0] addr_g, aligned_g, wdata_g, rd_ext;
    logic [3:0]  be_g;
    logic [15:0] sh;
    always_comb begin
        pick_d = d_req && (lock || !if_req || !last_d);
        // a pulse still showing belongs to the access just finished, so its req is not a new request
        go = (if_req || d_req) && !(if_done || if_abort || d_done || d_abort);
        size_g = pick_d ? d_size : 2'b10;
        addr_g = pick_d ? d_addr : if_addr;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        bad = pick_d && (d_size == 2'b11 || (d_size == 2'b10 && d_addr[1:0] != 2'b00) ||
                         (d_size == 2'b01 && d_addr[0]));
`else
        bad = pick_d && d_size == 2'b11;
`endif
        be_g = size_g == 2'b00 ? 4'b0001 << addr_g[1:0] :
               size_g == 2'b01 ? (addr_g[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        aligned_g = size_g == 2'b10 ? {addr_g[31:2], 2'b00} :
                    size_g == 2'b01 ? {addr_g[31:1], 1'b0} : addr_g;
        wdata_g = d_size == 2'b00 ? {4{d_wdata[7:0]}} :
                  d_size == 2'b01 ? {2{d_wdata[15:0]}} : d_wdata;
        sh = 16'(mem_rdata >> (sz == 2'b01 ? {off[1], 4'b0000} : {off, 3'b000}));
        rd_ext = sz == 2'b00 ? {24'h0, sh[7:0]} : sz == 2'b01 ? {16'h0, sh} : mem_rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
            if_done   <= 1'b0;
            if_abort  <= 1'b0;
            d_done    <= 1'b0;
            d_abort   <= 1'b0;
            lock      <= 1'b0;
            last_d    <= 1'b0;
            gnt_d     <= 1'b0;
            g_lock    <= 1'b0;
            sz        <= 2'b00;
            off       <= 2'b00;
            cnt       <= 8'h0;
        end else begin
            if_done  <= 1'b0;
            if_abort <= 1'b0;
            d_done   <= 1'b0;
            d_abort  <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    gnt_d     <= pick_d;
                    last_d    <= pick_d;
                    sz        <= size_g;
                    off       <= addr_g[1:0];
                    cnt       <= 8'h0;
                    mem_addr  <= aligned_g;
                    mem_be    <= be_g;
                    mem_we    <= pick_d && d_we;
                    mem_wdata <= pick_d ? wdata_g : 32'h0;
                    if (pick_d) begin
                        g_lock <= d_lock;
                        if (!d_lock) lock <= 1'b0;
                    end
                    if (bad) begin
                        state   <= ABORT;
                        d_abort <= 1'b1;
                    end else begin
                        state   <= BUS;
                        mem_req <= 1'b1;
                    end
                end
                BUS: if (mem_ready) begin
                    mem_req <= 1'b0;
                    state   <= RESP;
                    if (gnt_d) d_rdata <= rd_ext;
                    else if_rdata <= mem_rdata;
                end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    mem_req <= 1'b0;
                    state   <= ABORT;
                    if (gnt_d) d_abort <= 1'b1;
                    else if_abort <= 1'b1;
                end else begin
                    cnt <= cnt + 8'h1;
                end
                RESP: begin
                    state <= IDLE;
                    if (gnt_d) begin
                        d_done <= 1'b1;
                        lock   <= g_lock;
                    end else begin
                        if_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; stimulus queues expected bus beats and done/abort events, a monitor checks them.
module tb_mem_arbiter;
    logic        clk, rst;
    logic        if_req, if_done, if_abort;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_lock, d_done, d_abort;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    localparam logic [3:0] D_DONE = 4'b1000, D_ABT = 4'b0100, I_DONE = 4'b0010;

    typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} bus_t;
    typedef struct {logic [3:0] kind; logic [31:0] data; logic cd; int since_req; int since_prev;} evt_t;
    bus_t bq[$];
    evt_t eq[$];

    int n_checks = 0, n_fail = 0;
    int ready_lat = 1, bus_cnt = 0;
    logic spur = 1'b0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_abort(if_abort), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_done(d_done), .d_abort(d_abort), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected", name);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
        bus_t b;
        b.addr = a; b.be = be; b.wdata = wd; b.we = we;
        bq.push_back(b);
    endtask

    task automatic push_evt(input logic [3:0] k, input logic [31:0] d, input logic cd, input int sr, input int sp);
        evt_t e;
        e.kind = k; e.data = d; e.cd = cd; e.since_req = sr; e.since_prev = sp;
        eq.push_back(e);
    endtask

    // memory model: mem_ready on the ready_lat-th cycle of a bus beat
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                bus_cnt++;
                mem_ready = (bus_cnt == ready_lat);
            end else begin
                bus_cnt = 0;
                mem_ready = spur;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        int cyc = 0, rise_cyc = 0, last_evt = 0;
        logic prev = 1'b0;
        bus_t b;
        evt_t e;
        logic [3:0] k;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_req === 1'b1 && !prev) begin
                rise_cyc = cyc;
                if (bq.size() == 0) unexpected("bus_beat");
                else begin
                    b = bq.pop_front();
                    chk("mem_addr", mem_addr, b.addr);
                    chk("mem_be", {28'h0, mem_be}, {28'h0, b.be});
                    chk("mem_we", {31'h0, mem_we}, {31'h0, b.we});
                    if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
                end
            end
            prev = (mem_req === 1'b1);
            k = {d_done, d_abort, if_done, if_abort};
            if (k != 4'b0000 && !$isunknown(k)) begin
                if (eq.size() == 0) unexpected("done_abort");
                else begin
                    e = eq.pop_front();
                    chk("event_kind", {28'h0, k}, {28'h0, e.kind});
                    if (e.cd) chk(e.kind == I_DONE ? "if_rdata" : "d_rdata", e.kind == I_DONE ? if_rdata : d_rdata, e.data);
                    if (e.since_req >= 0) chk("latency_from_mem_req", cyc - rise_cyc, e.since_req);
                    if (e.since_prev >= 0) chk("event_spacing", cyc - last_evt, e.since_prev);
                    if (d_abort || if_abort) chk("mem_req_at_abort", {31'h0, mem_req}, 32'h0);
                end
                last_evt = cyc;
            end
        end
    end

    task automatic d_op(input logic we, input logic lk, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int lat, input logic early);
        int n = 0;
        mem_rdata = rd; ready_lat = lat;
        d_we = we; d_lock = lk; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (early && mem_req) d_req = 1'b0;
        end while (!(d_done || d_abort) && n < 100);
        chk("d_op_completes", {31'h0, d_done || d_abort}, 32'h1);
        d_req = 1'b0;
    endtask

    task automatic i_op(input logic [31:0] a, input logic [31:0] rd, input int lat);
        int n = 0;
        mem_rdata = rd; ready_lat = lat; if_addr = a; if_req = 1'b1;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(if_done || if_abort) && n < 100);
        chk("i_op_completes", {31'h0, if_done || if_abort}, 32'h1);
        if_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dc, ic;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0;
        d_addr = 32'h0; d_size = 2'b10; d_wdata = 32'h0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_pulses", {28'h0, d_done, d_abort, if_done, if_abort}, 32'h0);
        #1 rst = 1'b0;

        push_bus(32'h1001, 4'b0010, 32'hABABABAB, 1'b1);
        push_evt(D_DONE, 32'h0, 1'b0, 4, -1);
        d_op(1'b1, 1'b0, 2'b00, 32'h1001, 32'h000000AB, 32'h0, 3, 1'b0);

        push_bus(32'h1002, 4'b1100, 32'h0, 1'b0);
        push_evt(D_DONE, 32'h0000BEEF, 1'b1, 2, -1);
        d_op(1'b0, 1'b0, 2'b01, 32'h1002, 32'h0, 32'hBEEF1234, 1, 1'b0);

        push_bus(32'h1003, 4'b1000, 32'h0, 1'b0);
        push_evt(D_DONE, 32'h00000012, 1'b1, 3, -1);
        d_op(1'b0, 1'b0, 2'b00, 32'h1003, 32'h0, 32'h12345678, 2, 1'b0);

        push_bus(32'h2000, 4'b1111, 32'hDEADBEEF, 1'b1);
        push_evt(D_DONE, 32'h0, 1'b0, 2, -1);
        d_op(1'b1, 1'b0, 2'b10, 32'h2000, 32'hDEADBEEF, 32'h0, 1, 1'b0);

        push_bus(32'h2002, 4'b1100, 32'hABCDABCD, 1'b1);
        push_evt(D_DONE, 32'h0, 1'b0, 3, -1);
        d_op(1'b1, 1'b0, 2'b01, 32'h2002, 32'h1234ABCD, 32'h0, 2, 1'b0);

        push_bus(32'h5000, 4'b1111, 32'h0, 1'b0);
        push_evt(D_DONE, 32'h0F0F0F0F, 1'b1, 5, -1);
        d_op(1'b0, 1'b0, 2'b10, 32'h5000, 32'h0, 32'h0F0F0F0F, 4, 1'b1);

        push_bus(32'h6000, 4'b1111, 32'h0, 1'b0);
        push_evt(D_ABT, 32'h0, 1'b0, 16, -1);
        d_op(1'b0, 1'b0, 2'b10, 32'h6000, 32'h0, 32'h0, 255, 1'b0);

        push_evt(D_ABT, 32'h0, 1'b0, -1, -1);
        d_op(1'b0, 1'b0, 2'b11, 32'h7000, 32'h0, 32'h0, 1, 1'b0);

`ifdef MEM_ARB_ALIGN_CHECK_EN
        push_evt(D_ABT, 32'h0, 1'b0, -1, -1);
`else
        push_bus(32'h1000, 4'b1111, 32'h0, 1'b0);
        push_evt(D_DONE, 32'h55667788, 1'b1, 2, -1);
`endif
        d_op(1'b0, 1'b0, 2'b10, 32'h1003, 32'h0, 32'h55667788, 1, 1'b0);

        push_bus(32'h400, 4'b1111, 32'h0, 1'b0);
        push_evt(I_DONE, 32'hCAFEF00D, 1'b1, 2, -1);
        i_op(32'h400, 32'hCAFEF00D, 1);

        // both held: D, IF, D, IF four cycles apart
        for (int i = 0; i < 2; i++) begin
            push_bus(32'h3000, 4'b1111, 32'h0, 1'b0);
            push_bus(32'h500, 4'b1111, 32'h0, 1'b0);
            push_evt(D_DONE, 32'h11223344, 1'b1, 2, i == 0 ? -1 : 4);
            push_evt(I_DONE, 32'h11223344, 1'b1, 2, 4);
        end
        mem_rdata = 32'h11223344; ready_lat = 1;
        d_we = 1'b0; d_lock = 1'b0; d_size = 2'b10; d_addr = 32'h3000; if_addr = 32'h500;
        d_req = 1'b1; if_req = 1'b1;
        n = 0; dc = 0; ic = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (d_done) begin dc++; if (dc == 2) d_req = 1'b0; end
            if (if_done) begin ic++; if (ic == 2) if_req = 1'b0; end
        end while (!(dc == 2 && ic == 2) && n < 100);
        chk("rr_done_count", dc + ic, 4);
        d_req = 1'b0; if_req = 1'b0;

        // locked access, then a tie must still go to data; reset kills that beat
        push_bus(32'h4000, 4'b1111, 32'h0, 1'b0);
        push_evt(D_DONE, 32'h0BADF00D, 1'b1, 2, -1);
        d_op(1'b0, 1'b1, 2'b10, 32'h4000, 32'h0, 32'h0BADF00D, 1, 1'b0);
        push_bus(32'h4004, 4'b1111, 32'h0, 1'b0);
        ready_lat = 255; d_addr = 32'h4004; if_addr = 32'h600; d_req = 1'b1; if_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!mem_req && n < 20);
        chk("lock_bus_started", {31'h0, mem_req}, 32'h1);
        rst = 1'b1; d_req = 1'b0; if_req = 1'b0; d_lock = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_drops_mem_req", {31'h0, mem_req}, 32'h0);
        #1 rst = 1'b0;
        ready_lat = 1;
        repeat (10) @(posedge clk);
        #2;

        spur = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("spurious_ready_quiet", {27'h0, mem_req, d_done, d_abort, if_done, if_abort}, 32'h0);
            #1;
        end
        spur = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("events_left", eq.size(), 0);
        chk("bus_beats_left", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
